ms_timer_scheduler: RTL and testbench

Multi-channel millisecond timeout scheduler built around one shared time base. It divides `sys_clk` into a 1 ms tick and keeps a free-running 32-bit millisecond count. It also shares a single arming port among NCH requesters through round-robin arbitration, and raises a one-cycle expiry pulse per channel when that channel's armed duration has elapsed. It is the timing service that game and control logic use instead of instantiating private counters.

---
 rtl/timer_pkg.sv | 13 +
 rtl/rr_arbiter.sv | 37 +++
 rtl/ms_timer_scheduler.sv | 120 ++++++++++++
 tb/tb_ms_timer_scheduler.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Shared constants and sizing helper for the millisecond timer scheduler.
package timer_pkg;

  localparam int CLK_DIV_DEF = 50000;
  localparam int MS_W        = 32;
  localparam int DUR_W_DEF   = 16;

  // Width able to hold 0..n-1, never narrower than one bit.
  function automatic int ptr_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after i_ptr, searching modulo N.
module rr_arbiter
  import timer_pkg::*;
#(
  parameter int N = 4,
  localparam int PW = ptr_w(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [PW-1:0] i_ptr,
  output logic [N-1:0]  o_gnt,
  output logic          o_valid
);

  logic [2*N-1:0] w_dbl;
  logic [N-1:0]   w_rot;

  // Rotating a doubled copy puts the pointer's channel at bit 0.
  assign w_dbl   = {i_req, i_req} >> i_ptr;
  assign w_rot   = w_dbl[N-1:0];
  assign o_valid = |i_req;

  always_comb begin
    int pos;
    int idx;
    pos = 0;
    for (int k = N - 1; k >= 0; k--) begin
      if (w_rot[k]) pos = k;
    end
    idx = int'(i_ptr) + pos;
    if (idx >= N) idx = idx - N;
    o_gnt = '0;
    for (int j = 0; j < N; j++) begin
      o_gnt[j] = o_valid && (idx == j);
    end
  end

endmodule

// File: rtl/ms_timer_scheduler.sv
// Shared 1 ms time base with NCH round-robin-armed timeout channels.
module ms_timer_scheduler
  import timer_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEF,
  parameter int NCH     = 4,
  parameter int DUR_W   = DUR_W_DEF
) (
  input  logic                 i_sys_clk,
  input  logic                 i_rst,
  input  logic [NCH-1:0]       i_arm_req,
  input  logic [NCH*DUR_W-1:0] i_arm_dur,
  input  logic [NCH-1:0]       i_cancel,
  output logic [NCH-1:0]       o_arm_gnt,
  output logic [NCH-1:0]       o_active,
  output logic [NCH-1:0]       o_expired,
  output logic                 o_tick,
  output logic [MS_W-1:0]      o_milliseconds
);

  localparam int PW      = ptr_w(NCH);
  localparam int PRESC_W = ptr_w(CLK_DIV);
  localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(CLK_DIV - 1);

  logic [PRESC_W-1:0] r_presc;
  logic [MS_W-1:0]    r_ms;
  logic [PW-1:0]      r_rr;
  logic [NCH-1:0]     r_gnt;
  logic               r_tick;

  logic               w_wrap;
  logic [PRESC_W-1:0] w_presc_next;
  logic [MS_W-1:0]    w_ms_next;
  logic [NCH-1:0]     w_elig;
  logic [NCH-1:0]     w_gnt;
  logic               w_valid;
  logic [PW-1:0]      w_rr_next;

  assign w_wrap       = (r_presc == PRESC_MAX);
  assign w_presc_next = w_wrap ? '0 : r_presc + PRESC_W'(1);
  assign w_ms_next    = w_wrap ? r_ms + MS_W'(1) : r_ms;

  // A channel granted last cycle is masked so a held request is not accepted twice.
  assign w_elig = i_arm_req & ~r_gnt & ~i_cancel;

  rr_arbiter #(.N(NCH)) u_arb (
    .i_req   (w_elig),
    .i_ptr   (r_rr),
    .o_gnt   (w_gnt),
    .o_valid (w_valid)
  );

  always_comb begin
    w_rr_next = '0;
    for (int j = 0; j < NCH; j++) begin
      if (w_gnt[j]) w_rr_next = (j == NCH - 1) ? '0 : PW'(j + 1);
    end
  end

  // Count is rewritten every cycle so it always reflects the current register view.
  always_ff @(posedge i_sys_clk or posedge i_rst) begin
    if (i_rst) begin
      r_presc <= '0;
      r_ms    <= '0;
      r_rr    <= '0;
      r_gnt   <= '0;
      r_tick  <= 1'b0;
    end else begin
      r_presc <= w_presc_next;
      r_ms    <= w_ms_next;
      r_tick  <= w_wrap;
      r_gnt   <= w_gnt;
      if (w_valid) r_rr <= w_rr_next;
    end
  end

  assign o_arm_gnt      = r_gnt;
  assign o_tick         = r_tick;
  assign o_milliseconds = r_ms;

  generate
    for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
      logic [MS_W-1:0]  r_deadline;
      logic             r_active;
      logic             r_expired;
      logic [DUR_W-1:0] w_dur;
      logic [MS_W-1:0]  w_dur_ext;
      logic             w_hit;

      assign w_dur     = i_arm_dur[gi*DUR_W +: DUR_W];
      assign w_dur_ext = (w_dur == '0) ? MS_W'(1) : MS_W'(w_dur);
      // Compare against the count that becomes visible with this tick, so expired lines up with tick.
      assign w_hit     = w_wrap && r_active && (w_ms_next == r_deadline);

      // Deadline is based on the count shown in the grant cycle, so a grant on a tick edge still waits D ticks.
      always_ff @(posedge i_sys_clk or posedge i_rst) begin
        if (i_rst) begin
          r_deadline <= '0;
          r_active   <= 1'b0;
          r_expired  <= 1'b0;
        end else begin
          r_expired <= 1'b0;
          if (i_cancel[gi]) begin
            r_active <= 1'b0;
          end else if (w_gnt[gi]) begin
            r_active   <= 1'b1;
            r_deadline <= w_ms_next + w_dur_ext;
          end else if (w_hit) begin
            r_active  <= 1'b0;
            r_expired <= 1'b1;
          end
        end
      end

      assign o_active[gi]  = r_active;
      assign o_expired[gi] = r_expired;
    end
  endgenerate

endmodule

// File: tb/tb_ms_timer_scheduler.sv
// Scoreboard bench: an event-level model predicts grants/expiries, a negedge monitor compares.
module tb_ms_timer_scheduler;

  localparam int CLK_DIV = 4;
  localparam int NCH     = 4;
  localparam int DUR_W   = 16;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [NCH-1:0]       arm_req = '0;
  logic [NCH*DUR_W-1:0] arm_dur = '0;
  logic [NCH-1:0]       cancel  = '0;
  logic [NCH-1:0]       arm_gnt;
  logic [NCH-1:0]       active;
  logic [NCH-1:0]       expired;
  logic                 tick;
  logic [31:0]          milliseconds;

  always #5 clk = ~clk;

  ms_timer_scheduler #(.CLK_DIV(CLK_DIV), .NCH(NCH), .DUR_W(DUR_W)) dut (
    .i_sys_clk      (clk),
    .i_rst          (rst),
    .i_arm_req      (arm_req),
    .i_arm_dur      (arm_dur),
    .i_cancel       (cancel),
    .o_arm_gnt      (arm_gnt),
    .o_active       (active),
    .o_expired      (expired),
    .o_tick         (tick),
    .o_milliseconds (milliseconds)
  );

  typedef struct {
    int             cyc;
    logic [NCH-1:0] v;
  } ev_t;

  ev_t gnt_q[$];
  ev_t exp_q[$];

  // Reference state: cycle count since reset, elapsed ms, per-channel pending deadline.
  int             m_c     = 0;
  logic [31:0]    m_ticks = '0;
  logic [31:0]    m_off   = '0;
  logic [31:0]    m_ms    = '0;
  bit             m_tick  = 1'b0;
  int             m_rr    = 0;
  logic [NCH-1:0] m_gnt   = '0;
  bit             m_active [NCH];
  logic [31:0]    m_dl     [NCH];

  int n_checks = 0;
  int n_errors = 0;
  bit done       = 1'b0;
  bit final_done = 1'b0;

  task automatic model_reset();
    m_c = 0; m_ticks = '0; m_ms = '0; m_tick = 1'b0; m_rr = 0; m_gnt = '0;
    for (int i = 0; i < NCH; i++) begin
      m_active[i] = 1'b0;
      m_dl[i]     = '0;
    end
    gnt_q.delete();
    exp_q.delete();
  endtask

  task automatic model_step();
    logic [NCH-1:0] elig;
    logic [NCH-1:0] g;
    logic [NCH-1:0] e;
    logic [31:0]    d;
    int             win;
    m_c++;
    m_tick = ((m_c % CLK_DIV) == 0);
    if (m_tick) m_ticks++;
    m_ms = m_ticks + m_off;
    elig = arm_req & ~m_gnt & ~cancel;
    win  = -1;
    for (int k = 0; k < NCH; k++) begin
      int idx;
      idx = (m_rr + k) % NCH;
      if (win < 0 && elig[idx]) win = idx;
    end
    g = '0;
    e = '0;
    for (int i = 0; i < NCH; i++) begin
      d = 32'(arm_dur[i*DUR_W +: DUR_W]);
      if (d == 0) d = 1;
      if (cancel[i]) begin
        m_active[i] = 1'b0;
      end else if (i == win) begin
        m_active[i] = 1'b1;
        m_dl[i]     = m_ms + d;
        g[i]        = 1'b1;
      end else if (m_tick && m_active[i] && m_ms == m_dl[i]) begin
        m_active[i] = 1'b0;
        e[i]        = 1'b1;
      end
    end
    if (win >= 0) m_rr = (win + 1) % NCH;
    m_gnt = g;
    if (g != '0) gnt_q.push_back('{cyc: m_c, v: g});
    if (e != '0) exp_q.push_back('{cyc: m_c, v: e});
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) model_reset();
      else     model_step();
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", nm, m_c, act, exp);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        chk("rst_gnt", 32'(arm_gnt), 32'd0);
        chk("rst_active", 32'(active), 32'd0);
        chk("rst_expired", 32'(expired), 32'd0);
        chk("rst_tick", 32'(tick), 32'd0);
        chk("rst_ms", milliseconds, 32'd0);
      end else begin
        logic [NCH-1:0] exp_v;
        logic [NCH-1:0] act_v;
        bit             due;
        chk("tick", 32'(tick), 32'(m_tick));
        chk("milliseconds", milliseconds, m_ms);
        act_v = '0;
        for (int i = 0; i < NCH; i++) act_v[i] = m_active[i];
        chk("active", 32'(active), 32'(act_v));
        due   = (gnt_q.size() > 0) && (gnt_q[0].cyc == m_c);
        exp_v = due ? gnt_q.pop_front().v : '0;
        if (arm_gnt != '0 || due) chk("arm_gnt", 32'(arm_gnt), 32'(exp_v));
        due   = (exp_q.size() > 0) && (exp_q[0].cyc == m_c);
        exp_v = due ? exp_q.pop_front().v : '0;
        if (expired != '0 || due) chk("expired", 32'(expired), 32'(exp_v));
      end
      if (done && !final_done) begin
        chk("gnt_left", 32'(gnt_q.size()), 32'd0);
        chk("exp_left", 32'(exp_q.size()), 32'd0);
        final_done = 1'b1;
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
    for (int i = 0; i < NCH; i++) begin
      if (arm_gnt[i]) arm_req[i] = 1'b0;
    end
    cancel = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic arm(input int ch, input int dur);
    arm_req[ch]                 = 1'b1;
    arm_dur[ch*DUR_W +: DUR_W]  = DUR_W'(dur);
  endtask

  // Asserted just after a rising edge so the next falling edge observes the asynchronous clear.
  task automatic do_reset();
    @(posedge clk);
    #1;
    rst     = 1'b1;
    m_off   = '0;
    arm_req = '0;
    cancel  = '0;
    @(negedge clk);
    @(negedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    #1;
    rst = 1'b0;
    idle(20);

    for (int i = 0; i < NCH; i++) arm(i, 10);
    idle(50);

    arm(1, 3);
    idle(20);

    arm(2, 5);
    arm(3, 4);
    idle(12);
    arm(2, 5);
    cancel[3] = 1'b1;
    idle(30);

    do_reset();
    step();
    force dut.r_ms = 32'hFFFF_FFFE;
    m_off = 32'hFFFF_FFFE - m_ticks;
    step();
    release dut.r_ms;
    arm(0, 4);
    idle(24);
    arm(1, 0);
    idle(8);

    arm(0, 8);
    idle(8);
    do_reset();
    idle(40);

    for (int n = 0; n < 600; n++) begin
      step();
      for (int i = 0; i < NCH; i++) begin
        if (!arm_req[i] && $urandom_range(0, 9) == 0) arm(i, int'($urandom_range(0, 6)));
        if ($urandom_range(0, 29) == 0) cancel[i] = 1'b1;
      end
    end
    step();
    arm_req = '0;
    idle(40);

    done = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
